regfile8_write_port: RTL

- Write side of the eight-register register file.
- Holds eight WIDTH-bit registers and accepts one write per cycle through an address decoder.
- Drives all eight register values in parallel to the existing 8-to-1 read multiplexer, Q0..Q7 feeding A0..A7.
- Adds a sequenced clear-all operation with handshake, so software can zero the file without eight explicit writes.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/decoder3to8.sv | 15 +
 rtl/regfile8_write_port.sv | 86 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and state encoding for the eight-register file
package regfile_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/decoder3to8.sv
// rtl/decoder3to8.sv - 3-to-8 one-hot write-enable decoder
module decoder3to8
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile8_write_port.sv
// rtl/regfile8_write_port.sv - write side of the eight-register file with sequenced clear-all
module regfile8_write_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = regfile_pkg::WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  output logic              wr_rdy,
  input  logic              clr,
  output logic              clr_done,
  output logic              busy,
  output logic [WIDTH-1:0]  q0,
  output logic [WIDTH-1:0]  q1,
  output logic [WIDTH-1:0]  q2,
  output logic [WIDTH-1:0]  q3,
  output logic [WIDTH-1:0]  q4,
  output logic [WIDTH-1:0]  q5,
  output logic [WIDTH-1:0]  q6,
  output logic [WIDTH-1:0]  q7
);

  state_e              state, next_state;
  logic [ADDR_W-1:0]   idx;
  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic                dec_en;
  logic [ADDR_W-1:0]   dec_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [NUM_REGS-1:0] wr_sel;

  assign wr_rdy   = (state == IDLE) && !clr;
  assign busy     = (state == CLEAR) || (state == DONE);
  assign clr_done = (state == DONE);

  // The clear walk shares the decoder so every register has a single enable source.
  assign dec_en   = (state == CLEAR) || (we && wr_rdy);
  assign dec_addr = (state == CLEAR) ? idx : wa;
  assign wr_data  = (state == CLEAR) ? '0 : wd;

  decoder3to8 u_dec (
    .addr   (dec_addr),
    .en     (dec_en),
    .onehot (wr_sel)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clr) next_state = CLEAR;
      CLEAR:   if (idx == ADDR_W'(NUM_REGS - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) idx <= idx + 1'b1;
      else                idx <= '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst_n)        regs[i] <= '0;
      else if (wr_sel[i]) regs[i] <= wr_data;
    end
  end

  assign q0 = regs[0];
  assign q1 = regs[1];
  assign q2 = regs[2];
  assign q3 = regs[3];
  assign q4 = regs[4];
  assign q5 = regs[5];
  assign q6 = regs[6];
  assign q7 = regs[7];

endmodule
